bus_route_mux: RTL

//  Registered master-to-slave request router for the serial system bus; successor of the fixed 2x3 mux.

---
 rtl/bus_route_mux_pkg.sv | 24 ++
 rtl/bus_route_mux_if.sv | 24 ++
 rtl/bus_route_mux_onehot_idx.sv | 23 ++
 rtl/bus_route_mux.sv | 113 +++++++++++
 4 files changed

// File: rtl/bus_route_mux_pkg.sv
// bus_route_mux_pkg: shared FSM state encoding and the per-route bus signal bundle.
package bus_route_mux_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Signal-group order of one routed bus lane (MSB first).
    typedef struct packed {
        logic master_ready;
        logic master_valid;
        logic read_en;
        logic write_en;
        logic tx_address;
        logic tx_data;
        logic tx_burst;
        logic tx_done;
    } bus_bits_t;

    localparam int N_SIG = $bits(bus_bits_t);

endpackage

// File: rtl/bus_route_mux_if.sv
// bus_route_mux_if: W-lane bundle of the eight serial bus signals.
//   master modport drives the lanes, slave modport receives them.
interface bus_route_mux_if #(
    parameter int W = 2
);
    logic [W-1:0] master_ready;
    logic [W-1:0] master_valid;
    logic [W-1:0] read_en;
    logic [W-1:0] write_en;
    logic [W-1:0] tx_address;
    logic [W-1:0] tx_data;
    logic [W-1:0] tx_burst;
    logic [W-1:0] tx_done;

    modport master (
        output master_ready, master_valid, read_en, write_en,
               tx_address, tx_data, tx_burst, tx_done
    );

    modport slave (
        input  master_ready, master_valid, read_en, write_en,
               tx_address, tx_data, tx_burst, tx_done
    );
endinterface

// File: rtl/bus_route_mux_onehot_idx.sv
// onehot_idx: one-hot vector to index, with any-bit and exactly-one-hot flags.
//   vec   in   W    one-hot select vector
//   idx   out  IW   index of the set bit (meaningful only when legal)
//   any   out  1    at least one bit set
//   legal out  1    exactly one bit set
module onehot_idx #(
    parameter int W  = 2,
    parameter int IW = $clog2(W)
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          any,
    output logic          legal
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < W; i++)
            if (vec[i]) idx = idx | IW'(i);
    end

    assign any   = |vec;
    assign legal = any && ((vec & (vec - W'(1))) == '0);
endmodule

// File: rtl/bus_route_mux.sv
// bus_route_mux: registered master-to-slave request router with transaction lock and timeout.
//   clk, rstn            clock, async active-low reset (released synchronously)
//   bus_grant            one-hot master select from the arbiter
//   slave_grant          one-hot slave select from the decoder
//   m                    per-master request lanes (input)
//   s                    per-slave request lanes (registered output)
//   busy                 route locked (ACTIVE or RELEASE)
//   route_timeout        1-cycle pulse on forced release
//   grant_err            1-cycle pulse on malformed grant while idle
module bus_route_mux
    import bus_route_mux_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int N_SLAVES       = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_MASTERS-1:0] bus_grant,
    input  logic [N_SLAVES-1:0]  slave_grant,
    bus_route_mux_if.slave       m,
    bus_route_mux_if.master      s,
    output logic                 busy,
    output logic                 route_timeout,
    output logic                 grant_err
);
    localparam int IW_M = $clog2(N_MASTERS);
    localparam int IW_S = $clog2(N_SLAVES);
    localparam int CW   = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]      rst_sync;
    logic            rst_n_i;
    state_t          state, next_state;
    logic [IW_M-1:0] sel_m, gm_idx, src_m;
    logic [IW_S-1:0] sel_s, gs_idx, dst_s;
    logic            gm_any, gm_legal, gs_any, gs_legal;
    logic [CW-1:0]   cnt;
    bus_bits_t       src;
    logic            capture, done, to, err, load;
    bus_bits_t       s_q [N_SLAVES];

    // Assertion reaches every register at once; release is aligned to clk.
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) rst_sync <= '0;
        else       rst_sync <= {rst_sync[0], 1'b1};

    assign rst_n_i = rst_sync[1];

    onehot_idx #(.W(N_MASTERS)) u_gm (.vec(bus_grant),   .idx(gm_idx), .any(gm_any), .legal(gm_legal));
    onehot_idx #(.W(N_SLAVES))  u_gs (.vec(slave_grant), .idx(gs_idx), .any(gs_any), .legal(gs_legal));

    // While idle the live grant picks the route; once locked, grants are ignored.
    assign src_m = state == IDLE ? gm_idx : sel_m;
    assign dst_s = state == IDLE ? gs_idx : sel_s;
    assign src   = {m.master_ready[src_m], m.master_valid[src_m], m.read_en[src_m], m.write_en[src_m],
                    m.tx_address[src_m], m.tx_data[src_m], m.tx_burst[src_m], m.tx_done[src_m]};
    assign done  = src.tx_done;

    always_ff @(posedge clk or negedge rst_n_i)
        if (!rst_n_i) state <= IDLE;
        else          state <= next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = capture ? (done ? RELEASE : ACTIVE) : IDLE;
            ACTIVE:  next_state = (done || to) ? RELEASE : ACTIVE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        capture = state == IDLE && gm_legal && gs_legal && src.master_valid;
        err     = state == IDLE && (gm_any || gs_any) && !(gm_legal && gs_legal);
        // Done on the final count wins over the timeout.
        to      = TIMEOUT_CYCLES > 0 && state == ACTIVE && cnt == LAST && !done;
        load    = capture || (state == ACTIVE && !to);
    end

    always_ff @(posedge clk or negedge rst_n_i)
        if (!rst_n_i) begin
            sel_m         <= '0;
            sel_s         <= '0;
            cnt           <= '0;
            busy          <= 1'b0;
            route_timeout <= 1'b0;
            grant_err     <= 1'b0;
        end else begin
            if (capture) begin
                sel_m <= gm_idx;
                sel_s <= gs_idx;
            end
            cnt           <= capture ? '0 : state == ACTIVE ? cnt + CW'(1) : cnt;
            busy          <= next_state != IDLE;
            route_timeout <= to;
            grant_err     <= err;
        end

    for (genvar j = 0; j < N_SLAVES; j++) begin : g_slave
        always_ff @(posedge clk or negedge rst_n_i)
            if (!rst_n_i) s_q[j] <= '0;
            else          s_q[j] <= (load && dst_s == IW_S'(j)) ? src : '0;
        assign s.master_ready[j] = s_q[j].master_ready;
        assign s.master_valid[j] = s_q[j].master_valid;
        assign s.read_en[j]      = s_q[j].read_en;
        assign s.write_en[j]     = s_q[j].write_en;
        assign s.tx_address[j]   = s_q[j].tx_address;
        assign s.tx_data[j]      = s_q[j].tx_data;
        assign s.tx_burst[j]     = s_q[j].tx_burst;
        assign s.tx_done[j]      = s_q[j].tx_done;
    end
endmodule
